// File: rtl/riscv_mem.sv
// Memory-access stage of the 5-stage RISC-V pipeline: loads/stores over a req/gnt/rvalid
// port, branch resolution toward fetch, and registered results toward write-back.
module riscv_mem #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] alu_out_i,
    input  logic                 alu_zero_i,
    input  logic [WORD_SIZE-1:0] store_data_i,
    input  logic [WORD_SIZE-1:0] jp_addr_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic                 branch_i,
    input  logic                 reg_write_i,
    input  logic [4:0]           rd_i,
    output logic                 stall_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [WORD_SIZE-1:0] dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [WORD_SIZE-1:0] dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [WORD_SIZE-1:0] dmem_rdata_i,
    output logic                 wb_valid_o,
    output logic [WORD_SIZE-1:0] wb_data_o,
    output logic                 reg_write_o,
    output logic [4:0]           rd_o,
    output logic                 pc_src_o,
    output logic [WORD_SIZE-1:0] jp_addr_o,
    output logic                 misaligned_o,
    output logic [1:0]           state_o
);

    // Handshake: the request is accepted in any cycle where dmem_req_o & dmem_gnt_i;
    // addr/we/be/wdata stay stable from the first request cycle until that grant.
    // Load data is consumed in the cycle dmem_rvalid_i is high while in WAIT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic mem_acc, misaligned, aligned_acc;
    logic req, complete, stall_int, retire, load_done;
    logic [3:0]  be;
    logic [31:0] wdata, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mem_acc     = valid_i & (mem_read_i | mem_write_i);
    assign misaligned  = mem_acc & (((size_i == 2'b01) & alu_out_i[0]) |
                                    (size_i[1] & (alu_out_i[1:0] != 2'b00)));
    assign aligned_acc = mem_acc & ~misaligned;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data_i;
        case (size_i)
            2'b00: begin
                be    = 4'b0001 << alu_out_i[1:0];
                wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << alu_out_i[1:0];
                wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata_i[7:0];
        case (alu_out_i[1:0])
            2'd1:    byte_sel = dmem_rdata_i[15:8];
            2'd2:    byte_sel = dmem_rdata_i[23:16];
            2'd3:    byte_sel = dmem_rdata_i[31:24];
            default: ;
        endcase
        half_sel = alu_out_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_val = dmem_rdata_i;
        case (size_i)
            2'b00: load_val = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01: load_val = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_acc) begin
                    req = 1'b1;
                    if (!dmem_gnt_i)     state_d  = REQ;
                    else if (mem_read_i) state_d  = WAIT;
                    else                 complete = 1'b1;
                end
            end
            REQ: begin
                req = 1'b1;
                if (dmem_gnt_i) begin
                    if (mem_read_i) begin
                        state_d = WAIT;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_int = ((state_q != IDLE) | aligned_acc) & ~complete;
    assign retire    = valid_i & ~stall_int;
    assign load_done = complete & mem_read_i;

    assign stall_o      = rst_ni & stall_int;
    assign dmem_req_o   = rst_ni & req;
    assign dmem_we_o    = rst_ni & req & mem_write_i;
    assign dmem_be_o    = (rst_ni & req) ? be : 4'b0000;
    assign dmem_addr_o  = {alu_out_i[31:2], 2'b00};
    assign dmem_wdata_o = wdata;
    assign state_o      = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            reg_write_o  <= 1'b0;
            rd_o         <= 5'd0;
            pc_src_o     <= 1'b0;
            jp_addr_o    <= '0;
            misaligned_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_valid_o   <= retire;
            wb_data_o    <= load_done ? load_val : alu_out_i;
            reg_write_o  <= retire & reg_write_i & ~misaligned;
            rd_o         <= rd_i;
            pc_src_o     <= retire & branch_i & alu_zero_i;
            jp_addr_o    <= jp_addr_i;
            misaligned_o <= retire & misaligned;
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: directed test-plan cases, random mix, reset mid-load.
module tb_riscv_mem;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i, alu_zero_i, mem_read_i, mem_write_i, unsigned_i, branch_i, reg_write_i;
    logic [31:0] alu_out_i, store_data_i, jp_addr_i, dmem_rdata_i;
    logic [1:0]  size_i;
    logic [4:0]  rd_i;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o, jp_addr_o;
    logic [3:0]  dmem_be_o;
    logic        wb_valid_o, reg_write_o, pc_src_o, misaligned_o;
    logic [4:0]  rd_o;
    logic [1:0]  state_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [71:0] exp_q[$];
    logic [71:0] e;
    bit          retire_due = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_mem #(.WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .alu_out_i(alu_out_i),
        .alu_zero_i(alu_zero_i), .store_data_i(store_data_i), .jp_addr_i(jp_addr_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .branch_i(branch_i), .reg_write_i(reg_write_i), .rd_i(rd_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .reg_write_o(reg_write_o),
        .rd_o(rd_o), .pc_src_o(pc_src_o), .jp_addr_o(jp_addr_o),
        .misaligned_o(misaligned_o), .state_o(state_o)
    );

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) begin
            case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] r, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = (a == 2'd0) ? r[7:0] : (a == 2'd1) ? r[15:8] : (a == 2'd2) ? r[23:16] : r[31:24];
        h = a[1] ? r[31:16] : r[15:0];
        if (sz == 2'b00) return u ? {24'd0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return u ? {16'd0, h} : {{16{h[15]}}, h};
        return r;
    endfunction

    // Retirement monitor: every wb_valid_o pops one expected record, in order.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wb_data", wb_data_o, e[31:0]);
                    check_eq("rd", rd_o, e[68:64]);
                    check_eq("reg_write", reg_write_o, e[69]);
                    check_eq("pc_src", pc_src_o, e[70]);
                    check_eq("misaligned", misaligned_o, e[71]);
                    if (e[70]) check_eq("jp_addr", jp_addr_o, e[63:32]);
                end
            end else begin
                check_eq("idle_flags", {pc_src_o, misaligned_o}, 2'b00);
            end
        end
    end

    task automatic first_edge_check();
        check_eq("retire_time", wb_valid_o, retire_due);
        retire_due = 1'b0;
    endtask

    task automatic run_instr(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic br, input logic zero, input logic [31:0] jp,
                             input logic rw, input logic [4:0] rd, input logic [31:0] rdata,
                             input int gnt_dly, input int rv_dly);
        logic mis, acc;
        logic [31:0] edata;
        mis   = (rd_en | wr_en) & (((sz == 2'b01) & addr[0]) | (sz[1] & (addr[1:0] != 2'b00)));
        acc   = (rd_en | wr_en) & ~mis;
        edata = (acc & rd_en) ? exp_load(rdata, addr[1:0], sz, uns) : addr;
        exp_q.push_back({mis, br & zero, rw & ~mis, rd, jp, edata});

        valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; size_i = sz;
        unsigned_i = uns; alu_out_i = addr; store_data_i = sdata; branch_i = br;
        alu_zero_i = zero; jp_addr_i = jp; reg_write_i = rw; rd_i = rd;
        if (acc) begin
            for (int c = 0; c <= gnt_dly; c++) begin
                dmem_gnt_i = (c == gnt_dly);
                @(negedge clk_i);
                if (c == 0) first_edge_check();
                else begin
                    check_eq("early_retire", wb_valid_o, 0);
                    check_eq("state_req", state_o, 2'd1);
                end
                check_eq("req", dmem_req_o, 1);
                check_eq("we", dmem_we_o, wr_en);
                check_eq("be", dmem_be_o, exp_be(sz, addr[1:0]));
                check_eq("addr", dmem_addr_o, {addr[31:2], 2'b00});
                if (wr_en) check_eq("wdata", dmem_wdata_o, exp_wdata(sz, sdata));
                check_eq("stall_req", stall_o, !(wr_en && c == gnt_dly));
                @(posedge clk_i); #1;
            end
            dmem_gnt_i = 1'b0;
            if (rd_en) begin
                for (int c = 1; c <= rv_dly; c++) begin
                    dmem_rvalid_i = (c == rv_dly);
                    dmem_rdata_i  = (c == rv_dly) ? rdata : $urandom;
                    @(negedge clk_i);
                    check_eq("early_retire", wb_valid_o, 0);
                    check_eq("state_wait", state_o, 2'd2);
                    check_eq("req_wait", dmem_req_o, 0);
                    check_eq("stall_wait", stall_o, c != rv_dly);
                    @(posedge clk_i); #1;
                end
                dmem_rvalid_i = 1'b0;
            end
        end else begin
            dmem_gnt_i = 1'b0;
            @(negedge clk_i);
            first_edge_check();
            check_eq("req_none", dmem_req_o, 0);
            check_eq("stall_none", stall_o, 0);
            @(posedge clk_i); #1;
        end
        retire_due = 1'b1;
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0; mem_read_i = 1'b1; mem_write_i = 1'b0; branch_i = 1'b1;
        alu_zero_i = 1'b1; size_i = 2'b10; alu_out_i = {$urandom, 2'b00};
        @(negedge clk_i);
        first_edge_check();
        check_eq("req_invalid", dmem_req_o, 0);
        check_eq("stall_invalid", stall_o, 0);
        @(posedge clk_i); #1;
        mem_read_i = 1'b0; branch_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; size_i = 2'b10;
        unsigned_i = 1'b0; alu_out_i = 32'h100; store_data_i = 0; jp_addr_i = 0;
        alu_zero_i = 1'b0; branch_i = 1'b0; reg_write_i = 1'b0; rd_i = 0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 0;
        @(negedge clk_i);
        check_eq("rst_req", dmem_req_o, 0);
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_we_be", {dmem_we_o, dmem_be_o}, 0);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_regs", {wb_valid_o, reg_write_o, pc_src_o, misaligned_o, rd_o, wb_data_o, jp_addr_o}, 0);
        valid_i = 1'b0; mem_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // ALU op
        run_instr(0, 0, 2'b10, 0, 32'h1234, 0, 0, 0, 0, 1, 5'd5, 0, 0, 1);
        // SB at 0x103, grant two cycles late
        run_instr(0, 1, 2'b00, 0, 32'h103, 32'hAB, 0, 0, 0, 0, 5'd0, 0, 2, 1);
        // LB / LBU / LH from lane 2, minimum and delayed timing
        run_instr(1, 0, 2'b00, 0, 32'h102, 0, 0, 0, 0, 1, 5'd7, 32'h0080_0000, 0, 1);
        run_instr(1, 0, 2'b00, 1, 32'h102, 0, 0, 0, 0, 1, 5'd8, 32'h0080_0000, 1, 2);
        run_instr(1, 0, 2'b01, 0, 32'h102, 0, 0, 0, 0, 1, 5'd9, 32'h8001_0000, 2, 3);
        // misaligned LW and SH
        run_instr(1, 0, 2'b10, 0, 32'h101, 0, 0, 0, 0, 1, 5'd3, 0, 0, 1);
        run_instr(0, 1, 2'b01, 0, 32'h203, 32'h55AA, 0, 0, 0, 0, 5'd0, 0, 0, 1);
        // branches taken and not taken
        run_instr(0, 0, 2'b10, 0, 32'h0, 0, 1, 1, 32'h40, 0, 5'd0, 0, 0, 1);
        run_instr(0, 0, 2'b10, 0, 32'h4, 0, 1, 0, 32'h80, 0, 5'd0, 0, 0, 1);
        idle_cycle();
        // word / half stores, size 11 as word, LHU
        run_instr(0, 1, 2'b01, 0, 32'h302, 32'h1234_BEEF, 0, 0, 0, 0, 5'd0, 0, 0, 1);
        run_instr(0, 1, 2'b11, 0, 32'h400, 32'hDEAD_BEEF, 0, 0, 0, 0, 5'd0, 0, 1, 1);
        run_instr(1, 0, 2'b01, 1, 32'h500, 0, 0, 0, 0, 1, 5'd11, 32'h1234_F00D, 0, 1);
        idle_cycle();

        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (op)
                0: run_instr(0, 0, 2'b10, 0, a, 0, 0, 0, 0, 1, 5'($urandom), 0, 0, 1);
                1: run_instr(0, 0, 2'b10, 0, a, 0, 1, 1'($urandom), $urandom, 0, 5'($urandom), 0, 0, 1);
                2: run_instr(1, 0, 2'($urandom), 1'($urandom), a, 0, 0, 0, 0, 1, 5'($urandom),
                             $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
                default: run_instr(0, 1, 2'($urandom), 0, a, $urandom, 0, 0, 0, 0, 5'($urandom),
                                   0, $urandom_range(0, 3), 1);
            endcase
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        // reset while a load waits for rvalid; stale rvalid after release is ignored
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; size_i = 2'b10;
        alu_out_i = 32'h200; reg_write_i = 1'b1; rd_i = 5'd4; branch_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        first_edge_check();
        @(posedge clk_i); #1;
        dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        check_eq("mid_state_wait", state_o, 2'd2);
        check_eq("mid_stall", stall_o, 1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_req", dmem_req_o, 0);
        check_eq("mid_rst_stall", stall_o, 0);
        check_eq("mid_rst_state", state_o, 0);
        check_eq("mid_rst_wb", wb_valid_o, 0);
        valid_i = 1'b0; mem_read_i = 1'b0; reg_write_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        check_eq("stale_state", state_o, 0);
        check_eq("stale_req", dmem_req_o, 0);
        check_eq("stale_stall", stall_o, 0);
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        retire_due = 1'b0;
        idle_cycle();
        idle_cycle();

        check_eq("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
